// File: rtl/mps_cmd_pkg.sv
// Shared opcodes, FSM state encoding, register map and reset values for the command slave.
package mps_cmd_pkg;

    localparam int unsigned DW = 8;

    localparam logic [DW-1:0] OP_WRITE    = 8'h01;
    localparam logic [DW-1:0] OP_READ     = 8'h02;
    localparam logic [DW-1:0] OP_STATUS   = 8'h03;
    localparam logic [DW-1:0] OP_SOFT_RST = 8'h04;

    localparam logic [DW-1:0] CTRL_ADDR   = 8'h00;
    localparam logic [DW-1:0] THRESH_ADDR = 8'h01;

    localparam logic [DW-1:0] CTRL_RST    = 8'h00;
    localparam logic [DW-1:0] THRESH_RST  = 8'h80;
    localparam logic [DW-1:0] DEFAULT_RST = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        ADDR,
        WDATA,
        RDATA,
        STAT,
        ERR
    } cmd_state_e;

    // Power-on / soft-reset value of register idx.
    function automatic logic [DW-1:0] reg_rst_val(input int unsigned idx);
        logic [DW-1:0] val;
        if (idx == 32'(CTRL_ADDR)) begin
            val = CTRL_RST;
        end else if (idx == 32'(THRESH_ADDR)) begin
            val = THRESH_RST;
        end else begin
            val = DEFAULT_RST;
        end
        return val;
    endfunction

endpackage

// File: rtl/cmd_regfile.sv
// Configuration register file: one write port, one combinational read port, synchronous clear.
module cmd_regfile
    import mps_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned AW       = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_c_o,
    output logic          readout_en_o,
    output logic [DW-1:0] thresh_o
);

    logic [DW-1:0] mem_q [NUM_REGS];

    // Clear takes priority so a soft reset can never be overridden by a write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= reg_rst_val(i);
        end else if (clr_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= reg_rst_val(i);
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c_o    = mem_q[raddr_i];
    assign readout_en_o = mem_q[AW'(CTRL_ADDR)][0];
    assign thresh_o     = mem_q[AW'(THRESH_ADDR)];

endmodule

// File: rtl/cmd_slave.sv
// Byte-stream command slave: WRITE/READ/STATUS/SOFT_RESET frames framed by active-low SS.
// Build option: define CMD_AUTOINC_EN to keep WDATA/RDATA open with a wrapping address.
module cmd_slave
    import mps_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8
) (
    input  logic          SCLK,
    input  logic          sys_reset,
    input  logic          SS,
    input  logic [DW-1:0] MOSI,
    output logic [DW-1:0] MISO,
    input  logic          mem_full,
    input  logic          mem_empty,
    output logic          readout_en,
    output logic [DW-1:0] thresh,
    output logic          soft_rst
);

    localparam int unsigned  AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [DW-1:0] LAST_ADDR = 8'(NUM_REGS - 1);

    cmd_state_e    state_q, state_d, cur_st;
    logic          ss_q, ss_fall_c;
    logic          is_wr_q, is_wr_d;
    logic [DW-1:0] addr_q, addr_d, addr_nxt_c, raddr_c;
    logic          err_q, err_d;
    logic [DW-1:0] miso_q, miso_d;
    logic          soft_rst_q, soft_rst_d;
    logic          we_c, clr_c;
    logic [DW-1:0] rdata_c, rd_val_c;

    function automatic logic in_range(input logic [DW-1:0] a);
        return a <= LAST_ADDR;
    endfunction

    // ss_q resets low so a frame needs a fresh SS falling edge after reset.
    assign ss_fall_c  = ss_q & ~SS;
    assign addr_nxt_c = (addr_q == LAST_ADDR) ? 8'h00 :
                        (in_range(addr_q) ? addr_q + 8'd1 : addr_q);
    assign raddr_c    = (state_q == ADDR) ? MOSI : addr_nxt_c;
    assign rd_val_c   = in_range(raddr_c) ? rdata_c : 8'h00;

    // The SS falling-edge cycle already carries the opcode byte.
    always_comb begin
        cur_st = state_q;
        if (state_q == IDLE && ss_fall_c) cur_st = OPCODE;
    end

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        err_d      = err_q;
        miso_d     = 8'h00;
        soft_rst_d = 1'b0;
        we_c       = 1'b0;
        clr_c      = 1'b0;
        if (SS) begin
            state_d = IDLE;
        end else begin
            unique case (cur_st)
                IDLE, ERR: ;
                OPCODE: begin
                    case (MOSI)
                        OP_WRITE: begin
                            state_d = ADDR;
                            is_wr_d = 1'b1;
                        end
                        OP_READ: begin
                            state_d = ADDR;
                            is_wr_d = 1'b0;
                        end
                        OP_STATUS: begin
                            state_d = STAT;
                            miso_d  = {5'b0, err_q, mem_full, mem_empty};
                        end
                        OP_SOFT_RST: begin
                            state_d    = ERR;
                            soft_rst_d = 1'b1;
                            clr_c      = 1'b1;
                            err_d      = 1'b0;
                        end
                        default: begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                ADDR: begin
                    addr_d = MOSI;
                    if (!in_range(MOSI)) err_d = 1'b1;
                    if (is_wr_q) begin
                        state_d = WDATA;
                    end else begin
                        state_d = RDATA;
                        miso_d  = rd_val_c;
                    end
                end
                WDATA: begin
                    we_c = in_range(addr_q);
`ifdef CMD_AUTOINC_EN
                    addr_d = addr_nxt_c;
`else
                    state_d = ERR;
`endif
                end
                RDATA: begin
`ifdef CMD_AUTOINC_EN
                    addr_d = addr_nxt_c;
                    miso_d = rd_val_c;
`else
                    state_d = ERR;
`endif
                end
                STAT: state_d = ERR;
            endcase
        end
    end

    always_ff @(posedge SCLK or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q    <= IDLE;
            ss_q       <= 1'b0;
            is_wr_q    <= 1'b0;
            addr_q     <= 8'h00;
            err_q      <= 1'b0;
            miso_q     <= 8'h00;
            soft_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ss_q       <= SS;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            miso_q     <= miso_d;
            soft_rst_q <= soft_rst_d;
        end
    end

    cmd_regfile #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk_i        (SCLK),
        .rst_ni       (sys_reset),
        .clr_i        (clr_c),
        .we_i         (we_c),
        .waddr_i      (AW'(addr_q)),
        .wdata_i      (MOSI),
        .raddr_i      (AW'(raddr_c)),
        .rdata_c_o    (rdata_c),
        .readout_en_o (readout_en),
        .thresh_o     (thresh)
    );

    assign MISO     = miso_q;
    assign soft_rst = soft_rst_q;

endmodule

// File: tb/tb_cmd_slave.sv
// Self-checking bench for cmd_slave: register model plus a MISO scoreboard queue.
module tb_cmd_slave;

    logic       SCLK, sys_reset, SS, mem_full, mem_empty, readout_en, soft_rst;
    logic [7:0] MOSI, MISO, thresh;

    cmd_slave #(.NUM_REGS(8)) dut (
        .SCLK       (SCLK),
        .sys_reset  (sys_reset),
        .SS         (SS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .mem_full   (mem_full),
        .mem_empty  (mem_empty),
        .readout_en (readout_en),
        .thresh     (thresh),
        .soft_rst   (soft_rst)
    );

    initial begin
        SCLK = 1'b0;
        forever #5 SCLK = ~SCLK;
    end

    logic [7:0] mdl [8];
    bit         mdl_err;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;
    int         checks = 0;
    int         errors = 0;

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        mdl[1]  = 8'h80;
        mdl_err = 1'b0;
    endtask

    task automatic step();
        @(posedge SCLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        SS   = 1'b0;
        MOSI = b;
        step();
    endtask

    task automatic end_frame();
        SS   = 1'b1;
        MOSI = 8'h00;
        step();
        step();
    endtask

    task automatic test_reset();
        sys_reset = 1'b0; SS = 1'b1; MOSI = 8'h00; mem_full = 1'b0; mem_empty = 1'b0;
        mdl_reset();
        step(); step();
        checks++; if (MISO !== 8'h00) begin errors++; $display("FAIL reset_miso: got %h want 00", MISO); end
        checks++; if (soft_rst !== 1'b0) begin errors++; $display("FAIL reset_soft_rst: got %b want 0", soft_rst); end
        checks++; if (readout_en !== mdl[0][0]) begin errors++; $display("FAIL reset_readout_en: got %b want %b", readout_en, mdl[0][0]); end
        checks++; if (thresh !== mdl[1]) begin errors++; $display("FAIL reset_thresh: got %h want %h", thresh, mdl[1]); end
        sys_reset = 1'b1;
        step(); step();
    endtask

    task automatic test_read_thresh();
        send(8'h02);
        exp_q.push_back(mdl[1]);
        send(8'h01);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL read_thresh: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
        checks++; if (MISO !== 8'h00) begin errors++; $display("FAIL idle_miso: got %h want 00", MISO); end
    endtask

    task automatic test_write_ctrl();
        send(8'h01); send(8'h00); send(8'h01);
        mdl[0] = 8'h01;
        checks++; if (readout_en !== mdl[0][0]) begin errors++; $display("FAIL write_readout_en: got %b want %b", readout_en, mdl[0][0]); end
        end_frame();
        send(8'h02);
        exp_q.push_back(mdl[0]);
        send(8'h00);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL read_ctrl: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
    endtask

    task automatic test_status();
        mem_full = 1'b0; mem_empty = 1'b1;
        exp_q.push_back({5'b0, mdl_err, mem_full, mem_empty});
        send(8'h03);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL status_clean: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
        send(8'h7F); mdl_err = 1'b1;
        send(8'h11); send(8'h22);
        checks++; if (MISO !== 8'h00) begin errors++; $display("FAIL err_sink_miso: got %h want 00", MISO); end
        end_frame();
        mem_full = 1'b1; mem_empty = 1'b0;
        exp_q.push_back({5'b0, mdl_err, mem_full, mem_empty});
        send(8'h03);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL status_err: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
        mem_full = 1'b0;
    endtask

    task automatic test_partial_write();
        send(8'h01); send(8'h01);
        end_frame();
        checks++; if (thresh !== mdl[1]) begin errors++; $display("FAIL partial_write_thresh: got %h want %h", thresh, mdl[1]); end
        checks++; if (MISO !== 8'h00) begin errors++; $display("FAIL partial_write_miso: got %h want 00", MISO); end
        send(8'h02);
        exp_q.push_back(mdl[1]);
        send(8'h01);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL partial_write_readback: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
    endtask

    task automatic test_soft_reset();
        send(8'h01); send(8'h01); send(8'h10);
        mdl[1] = 8'h10;
        end_frame();
        checks++; if (thresh !== mdl[1]) begin errors++; $display("FAIL thresh_written: got %h want %h", thresh, mdl[1]); end
        send(8'h04);
        mdl_reset();
        checks++; if (soft_rst !== 1'b1) begin errors++; $display("FAIL soft_rst_pulse: got %b want 1", soft_rst); end
        checks++; if (thresh !== mdl[1]) begin errors++; $display("FAIL soft_rst_thresh: got %h want %h", thresh, mdl[1]); end
        checks++; if (readout_en !== mdl[0][0]) begin errors++; $display("FAIL soft_rst_ctrl: got %b want %b", readout_en, mdl[0][0]); end
        send(8'h00);
        checks++; if (soft_rst !== 1'b0) begin errors++; $display("FAIL soft_rst_width: got %b want 0", soft_rst); end
        end_frame();
        exp_q.push_back({5'b0, mdl_err, mem_full, mem_empty});
        send(8'h03);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL soft_rst_err_clear: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
    endtask

    task automatic test_back_to_back();
        send(8'h01); send(8'h02); send(8'hAA); send(8'hBB);
        end_frame();
        mdl[2] = 8'hAA;
`ifdef CMD_AUTOINC_EN
        mdl[3] = 8'hBB;
`endif
        for (int a = 2; a < 4; a++) begin
            send(8'h02);
            exp_q.push_back(mdl[a]);
            send(8'(a));
            exp_v = exp_q.pop_front();
            checks++; if (MISO !== exp_v) begin errors++; $display("FAIL b2b_read reg%0d: got %h want %h", a, MISO, exp_v); end
            send(8'h00);
            SS = 1'b1; step();
        end
        step();
        send(8'h01); send(8'h07); send(8'hA5); send(8'h5A);
        end_frame();
        mdl[7] = 8'hA5;
`ifdef CMD_AUTOINC_EN
        mdl[0] = 8'h5A;
`endif
        checks++; if (readout_en !== mdl[0][0]) begin errors++; $display("FAIL wrap_ctrl: got %b want %b", readout_en, mdl[0][0]); end
        for (int k = 0; k < 2; k++) begin
            send(8'h02);
            exp_q.push_back(mdl[(k == 0) ? 7 : 0]);
            send((k == 0) ? 8'h07 : 8'h00);
            exp_v = exp_q.pop_front();
            checks++; if (MISO !== exp_v) begin errors++; $display("FAIL wrap_read step%0d: got %h want %h", k, MISO, exp_v); end
            send(8'h00);
            end_frame();
        end
`ifdef CMD_AUTOINC_EN
        send(8'h02);
        for (int a = 6; a < 9; a++) begin
            exp_q.push_back(mdl[a % 8]);
            send((a == 6) ? 8'h06 : 8'h00);
            exp_v = exp_q.pop_front();
            checks++; if (MISO !== exp_v) begin errors++; $display("FAIL autoinc_read addr%0d: got %h want %h", a % 8, MISO, exp_v); end
        end
        end_frame();
`endif
        exp_q.push_back({5'b0, mdl_err, mem_full, mem_empty});
        send(8'h03);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL sink_err_unchanged: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
    endtask

    task automatic test_out_of_range();
        send(8'h01); send(8'h08); send(8'h55);
        end_frame();
        mdl_err = 1'b1;
        send(8'h02);
        exp_q.push_back(8'h00);
        send(8'h09);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL oor_read: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
        send(8'h02);
        exp_q.push_back(mdl[0]);
        send(8'h00);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL oor_no_alias: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
        exp_q.push_back({5'b0, mdl_err, mem_full, mem_empty});
        send(8'h03);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL oor_err: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
    endtask

    task automatic test_reset_midframe();
        send(8'h01); send(8'h01); send(8'h33);
        mdl[1] = 8'h33;
        end_frame();
        send(8'h02);
        exp_q.push_back(mdl[1]);
        send(8'h01);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL midframe_pre_read: got %h want %h", MISO, exp_v); end
        #2 sys_reset = 1'b0;
        mdl_reset();
        #1;
        checks++; if (MISO !== 8'h00) begin errors++; $display("FAIL async_reset_miso: got %h want 00", MISO); end
        checks++; if (thresh !== mdl[1]) begin errors++; $display("FAIL async_reset_thresh: got %h want %h", thresh, mdl[1]); end
        step();
        sys_reset = 1'b1;
        send(8'h02); send(8'h01);
        checks++; if (MISO !== 8'h00) begin errors++; $display("FAIL no_frame_without_fall: got %h want 00", MISO); end
        end_frame();
        send(8'h02);
        exp_q.push_back(mdl[1]);
        send(8'h01);
        exp_v = exp_q.pop_front();
        checks++; if (MISO !== exp_v) begin errors++; $display("FAIL post_reset_read: got %h want %h", MISO, exp_v); end
        send(8'h00);
        end_frame();
    endtask

    initial begin
        test_reset();
        test_read_thresh();
        test_write_ctrl();
        test_status();
        test_partial_write();
        test_soft_reset();
        test_back_to_back();
        test_out_of_range();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
